// File: rtl/mac16_mult_seq_pkg.sv
// Shared types and widths for the sequential RV32M multiplier.
// The MAC sub-module and the sequencer both import this package.
package mult_seq_pkg;

  localparam int HALF_W = 16;
  localparam int MAC_W  = 35;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ALBL = 3'd1,
    ALBH = 3'd2,
    AHBL = 3'd3,
    AHBH = 3'd4,
    DONE = 3'd5
  } mult_state_e;

endpackage

// File: rtl/mac16_mult_seq_if.sv
// Request/response bundle between issue, the multiplier and writeback.
// A transfer happens on a rising edge where valid and ready are both high; valid never waits for ready.
interface mac16_mult_seq_if;
  import mult_seq_pkg::*;

  logic          req_valid_i;
  logic          req_ready_o;
  mul_op_e       op_i;
  logic [31:0]   op_a_i;
  logic [31:0]   op_b_i;
  logic          kill_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [31:0]   result_o;
  logic          busy_o;

  modport master (
    output req_valid_i, op_i, op_a_i, op_b_i, kill_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, busy_o
  );

  modport slave (
    input  req_valid_i, op_i, op_a_i, op_b_i, kill_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, busy_o
  );

endinterface

// File: rtl/mac16_mult_seq_mac17x17.sv
// Combinational 17x17 signed multiply-accumulate: p = sext17(x,sx) * sext17(y,sy) + acc.
// The accumulator never overflows because every partial sum stays below 2^34 in magnitude.
module mac17x17
  import mult_seq_pkg::*;
(
  input  logic [HALF_W-1:0]       x,
  input  logic                    sx,
  input  logic [HALF_W-1:0]       y,
  input  logic                    sy,
  input  logic signed [MAC_W-1:0] acc,
  output logic signed [MAC_W-1:0] p
);

  logic signed [HALF_W:0]       xs;
  logic signed [HALF_W:0]       ys;
  logic signed [2*HALF_W+1:0]   prod;

  assign xs   = {sx & x[HALF_W-1], x};
  assign ys   = {sy & y[HALF_W-1], y};
  assign prod = xs * ys;
  assign p    = {prod[2*HALF_W+1], prod} + acc;

endmodule

// File: rtl/mac16_mult_seq.sv
// Sequencer walking the four 16x16 partial products on one shared MAC.
// m_q carries the running sum at weight 2^16; lo_q collects the low result word.
module mac16_mult_seq
  import mult_seq_pkg::*;
#(
  parameter bit MulEarlyDone = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mac16_mult_seq_if.slave bus,
  output mult_state_e    dbg_state
);

  mult_state_e state_q, state_d;

  mul_op_e                 op_q;
  logic [31:0]             a_q, b_q, lo_q, result_q;
  logic                    sign_a_q, sign_b_q;
  logic signed [MAC_W-1:0] m_q;

  logic [HALF_W-1:0]       mac_x, mac_y;
  logic                    mac_sx, mac_sy;
  logic signed [MAC_W-1:0] mac_acc, mac_p;
  logic                    early_done;

  assign early_done = MulEarlyDone && (op_q == MUL);

  mac17x17 u_mac (
    .x   (mac_x),
    .sx  (mac_sx),
    .y   (mac_y),
    .sy  (mac_sy),
    .acc (mac_acc),
    .p   (mac_p)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mac_x   = '0;
    mac_sx  = 1'b0;
    mac_y   = '0;
    mac_sy  = 1'b0;
    mac_acc = '0;
    case (state_q)
      IDLE: if (bus.req_valid_i) state_d = ALBL;
      ALBL: begin
        mac_x   = a_q[15:0];
        mac_y   = b_q[15:0];
        state_d = ALBH;
      end
      ALBH: begin
        mac_x   = a_q[15:0];
        mac_y   = b_q[31:16];
        mac_sy  = sign_b_q;
        mac_acc = m_q;
        state_d = AHBL;
      end
      AHBL: begin
        mac_x   = a_q[31:16];
        mac_sx  = sign_a_q;
        mac_y   = b_q[15:0];
        mac_acc = m_q;
        state_d = early_done ? DONE : AHBH;
      end
      AHBH: begin
        mac_x   = a_q[31:16];
        mac_sx  = sign_a_q;
        mac_y   = b_q[31:16];
        mac_sy  = sign_b_q;
        mac_acc = m_q >>> 16;
        state_d = DONE;
      end
      DONE: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush beats both the response handshake and any state advance.
    if (state_q != IDLE && bus.kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= MUL;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      m_q      <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (state_q == IDLE) begin
      if (bus.req_valid_i) begin
        op_q     <= bus.op_i;
        a_q      <= bus.op_a_i;
        b_q      <= bus.op_b_i;
        sign_a_q <= (bus.op_i == MULH) || (bus.op_i == MULHSU);
        sign_b_q <= (bus.op_i == MULH);
      end
    end else if (!bus.kill_i) begin
      case (state_q)
        ALBL: begin
          lo_q[15:0] <= mac_p[15:0];
          m_q        <= {19'b0, mac_p[31:16]};
        end
        ALBH: m_q <= mac_p;
        AHBL: begin
          m_q         <= mac_p;
          lo_q[31:16] <= mac_p[15:0];
          if (early_done) result_q <= {mac_p[15:0], lo_q[15:0]};
        end
        AHBH: result_q <= (op_q == MUL) ? lo_q : mac_p[31:0];
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == DONE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.result_o     = result_q;
  assign dbg_state        = state_q;

endmodule
